// File: rtl/shift_issue_unit.sv
// shift_issue_unit: FIFO-buffered issue stage around Shifter_grace with a valid/ready result register.
// Define SHIFT_ISSUE_STATS_EN to add the OpCount output-handshake counter.
module Shifter_grace #(
  parameter int BitWidth = 32
) (
  input  logic                        En,
  input  logic                        Left,
  input  logic                        Rotate,
  input  logic [BitWidth-1:0]         Data,
  input  logic [$clog2(BitWidth)-1:0] Amount,
  output logic [BitWidth-1:0]         dOUT
);
  logic [2*BitWidth-1:0] dl, dr;
  // Shifting the doubled word yields the rotation in one half
  assign dl = {Data, Data} << Amount;
  assign dr = {Data, Data} >> Amount;
  always_comb dOUT = !En ? '0 : Left ? (Rotate ? dl[2*BitWidth-1:BitWidth] : Data << Amount)
                                     : (Rotate ? dr[BitWidth-1:0] : Data >> Amount);
endmodule

module shift_issue_unit #(
  parameter int BitWidth = 32,
  parameter int Depth    = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Flush,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic                        InLeft,
  input  logic                        InRotate,
  input  logic [BitWidth-1:0]         InData,
  input  logic [$clog2(BitWidth)-1:0] InAmount,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [BitWidth-1:0]         OutData,
`ifdef SHIFT_ISSUE_STATS_EN
  output logic [31:0]                 OpCount,
`endif
  output logic                        Busy
);
  localparam int ShiftWidth = $clog2(BitWidth);
  localparam int PtrWidth   = $clog2(Depth);
  localparam int EntryWidth = BitWidth + ShiftWidth + 2;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [EntryWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
  logic [PtrWidth:0]     count;
  logic [0:0]            state;
  logic                  push, issue;
  logic [EntryWidth-1:0] head;
  logic [BitWidth-1:0]   result;
  assign InReady  = count != (PtrWidth+1)'(Depth);
  assign push     = InValid && InReady;
  assign issue    = count != '0 && (state == EMPTY || OutReady);
  assign head     = mem[rd_ptr];
  assign OutValid = state == FULL;
  assign Busy     = count != '0 || OutValid;
  Shifter_grace #(.BitWidth(BitWidth)) u_shifter (
    .En    (issue),
    .Left  (issue && head[EntryWidth-1]),
    .Rotate(issue && head[EntryWidth-2]),
    .Data  (issue ? head[BitWidth+ShiftWidth-1:ShiftWidth] : '0),
    .Amount(issue ? head[ShiftWidth-1:0] : '0),
    .dOUT  (result)
  );
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= {InLeft, InRotate, InData, InAmount};
  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= EMPTY;
      if (Rst) OutData <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (issue) rd_ptr <= rd_ptr + PtrWidth'(1);
      count <= count + (PtrWidth+1)'(push) - (PtrWidth+1)'(issue);
      if (issue) begin
        OutData <= result;
        state   <= FULL;
      end else if (OutReady) state <= EMPTY;
    end
  end
`ifdef SHIFT_ISSUE_STATS_EN
  always_ff @(posedge Clk)
    if (Rst || Flush) OpCount <= '0;
    else if (OutValid && OutReady) OpCount <= OpCount + 32'd1;
`endif
endmodule
